// File: rtl/sauto_nav_ctrl_if.sv
// sauto_nav_ctrl_if: detector/command inputs and drive outputs of the navigation controller
//   i_enable, i_auto_mode            mode levels from the top-level FSM
//   i_cmd_forward/left/right         user direction commands (levels)
//   i_front/left/right_det           obstacle detectors (1 = blocked, asynchronous)
//   o_move_forward/turn_left/right   drive bits to the UART mux
//   o_waiting, o_nav_state           WAIT flag and current state code
//   o_turn_count                     completed turns, saturating
interface sauto_nav_ctrl_if #(parameter int CNT_W = 8);
   logic i_enable, i_auto_mode, i_cmd_forward, i_cmd_left, i_cmd_right;
   logic i_front_det, i_left_det, i_right_det;
   logic o_move_forward, o_turn_left, o_turn_right, o_waiting;
   logic [2:0] o_nav_state;
   logic [CNT_W-1:0] o_turn_count;
   modport master (
      output i_enable, i_auto_mode, i_cmd_forward, i_cmd_left, i_cmd_right,
      output i_front_det, i_left_det, i_right_det,
      input o_move_forward, o_turn_left, o_turn_right, o_waiting, o_nav_state, o_turn_count
   );
   modport slave (
      input i_enable, i_auto_mode, i_cmd_forward, i_cmd_left, i_cmd_right,
      input i_front_det, i_left_det, i_right_det,
      output o_move_forward, o_turn_left, o_turn_right, o_waiting, o_nav_state, o_turn_count
   );
endinterface

// File: rtl/sauto_nav_ctrl.sv
// sauto_nav_ctrl: semi-/full-auto navigation controller turning detector readings into drive bits
//   clk, rst_n   system clock, asynchronous active-low reset
//   nav          sauto_nav_ctrl_if.slave carrying mode, commands, detectors and drive outputs
module sauto_nav_ctrl #(
   parameter int TICK_DIV   = 100000,
   parameter int TURN_MS    = 900,
   parameter int SETTLE_MS  = 200,
   parameter int DEBOUNCE_N = 3,
   parameter int CNT_W      = 8
) (
   input logic clk,
   input logic rst_n,
   sauto_nav_ctrl_if.slave nav
);
   localparam int TMAX = (2 * TURN_MS > SETTLE_MS) ? 2 * TURN_MS : SETTLE_MS;
   localparam int TW = $clog2(TMAX + 1);
   localparam int DW = $clog2(TICK_DIV);
   localparam int SW = $clog2(DEBOUNCE_N + 1);
   typedef enum logic [2:0] {IDLE = 3'd0, CRUISE = 3'd1, WAIT = 3'd2, TURN = 3'd3, SETTLE = 3'd4, UTURN = 3'd5} state_t;
   state_t r_state;
   logic [2:0] r_sync1, r_sync2, r_prev;
   logic [DW-1:0] r_tick_cnt;
   logic [SW-1:0] r_stab;
   logic [TW-1:0] r_timer;
   logic [CNT_W-1:0] r_count;
   logic r_dir;
   logic r_mf, r_tl, r_tr, r_wait;
   logic w_tick, w_stable, w_settle_done, w_f_clr, w_l_clr, w_r_clr;
   logic w_m_f, w_m_l, w_m_r, w_go_f, w_go_l, w_go_r;
   logic [1:0] w_open;
   // decisions use the last debounced sample {front,left,right}
   assign w_tick = nav.i_enable && r_tick_cnt == DW'(TICK_DIV - 1);
   assign w_stable = r_stab == SW'(DEBOUNCE_N);
   assign w_settle_done = r_state == SETTLE && r_timer == '0;
   assign w_f_clr = !r_prev[2];
   assign w_l_clr = !r_prev[1];
   assign w_r_clr = !r_prev[0];
   assign w_open = 2'(w_f_clr) + 2'(w_l_clr) + 2'(w_r_clr);
   // manual: forward > left > right among clear commanded directions; auto: left-hand rule
   assign w_m_f = nav.i_cmd_forward && w_f_clr;
   assign w_m_l = nav.i_cmd_left && w_l_clr;
   assign w_m_r = nav.i_cmd_right && w_r_clr;
   assign w_go_f = nav.i_auto_mode ? (!w_l_clr && w_f_clr) : w_m_f;
   assign w_go_l = nav.i_auto_mode ? w_l_clr : (!w_m_f && w_m_l);
   assign w_go_r = nav.i_auto_mode ? (!w_l_clr && !w_f_clr && w_r_clr) : (!w_m_f && !w_m_l && w_m_r);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev <= '0;
         r_tick_cnt <= '0;
         r_stab <= '0;
      end else begin
         r_sync1 <= {nav.i_front_det, nav.i_left_det, nav.i_right_det};
         r_sync2 <= r_sync1;
         r_tick_cnt <= (!nav.i_enable || w_tick) ? '0 : r_tick_cnt + 1'b1;
         if (!nav.i_enable || w_settle_done)
            r_stab <= '0;
         else if (w_tick) begin
            r_prev <= r_sync2;
            r_stab <= (r_sync2 != r_prev) ? SW'(1) : (w_stable ? r_stab : r_stab + 1'b1);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_dir <= 1'b0;
         r_count <= '0;
         r_mf <= 1'b0;
         r_tl <= 1'b0;
         r_tr <= 1'b0;
         r_wait <= 1'b0;
      end else begin
         r_mf <= r_state == CRUISE || r_state == SETTLE;
         r_tl <= r_state == TURN && !r_dir;
         r_tr <= (r_state == TURN && r_dir) || r_state == UTURN;
         r_wait <= r_state == WAIT;
         if (!nav.i_enable) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_dir <= 1'b0;
         end else begin
            case (r_state)
               IDLE: r_state <= CRUISE;
               CRUISE: if (w_tick && w_stable) begin
                  if (w_open >= 2'd2)
                     r_state <= WAIT;
                  else if (w_open == 2'd1 && !w_f_clr) begin
                     r_state <= TURN;
                     r_dir <= w_r_clr;
                     r_timer <= TW'(TURN_MS);
                  end else if (w_open == 2'd0) begin
                     r_state <= UTURN;
                     r_timer <= TW'(2 * TURN_MS);
                  end
               end
               WAIT: if (w_go_f) begin
                  r_state <= SETTLE;
                  r_timer <= TW'(SETTLE_MS);
               end else if (w_go_l || w_go_r) begin
                  r_state <= TURN;
                  r_dir <= w_go_r;
                  r_timer <= TW'(TURN_MS);
               end
               TURN, UTURN: if (r_timer == '0) begin
                  r_state <= SETTLE;
                  r_timer <= TW'(SETTLE_MS);
                  r_count <= (r_count == '1) ? r_count : r_count + 1'b1;
               end else if (w_tick)
                  r_timer <= r_timer - 1'b1;
               SETTLE: if (r_timer == '0)
                  r_state <= CRUISE;
               else if (w_tick)
                  r_timer <= r_timer - 1'b1;
               default: r_state <= IDLE;
            endcase
         end
      end
   end
   assign nav.o_move_forward = r_mf;
   assign nav.o_turn_left = r_tl;
   assign nav.o_turn_right = r_tr;
   assign nav.o_waiting = r_wait;
   assign nav.o_nav_state = r_state;
   assign nav.o_turn_count = r_count;
endmodule
